// File: rtl/uart_pkg.sv
// Shared constants for the UART Avalon controller: register map, bit positions, widths.
package uart_pkg;

  localparam int DIV_W = 16;
  localparam int CTRL_W = 4;
  localparam int STATUS_W = 6;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_TX_FULL      = 2;
  localparam int ST_RX_FULL      = 3;
  localparam int ST_RX_OVERRUN   = 4;
  localparam int ST_TX_OVERFLOW  = 5;

  // CONTROL bit positions (flush bits are write-only strobes)
  localparam int CTRL_TX_EN    = 0;
  localparam int CTRL_IE_RX    = 1;
  localparam int CTRL_IE_TX    = 2;
  localparam int CTRL_IE_ERR   = 3;
  localparam int CTRL_FLUSH_TX = 8;
  localparam int CTRL_FLUSH_RX = 9;

endpackage

// File: rtl/uart_avalon_ctrl_if.sv
// Avalon-MM slave bus bundle for the UART controller, including its interrupt line.
interface uart_avalon_ctrl_if;
  import uart_pkg::*;

  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush. Pointers carry one extra wrap bit so full and
// empty are distinguishable; the head entry is visible combinationally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

  // Pointer next-state: flush discards everything, including a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/uart_avalon_ctrl.sv
// UART controller: Avalon register file, baud tick generator, TX/RX FIFOs,
// sticky error flags and a registered level interrupt.
module uart_avalon_ctrl
  import uart_pkg::*;
#(
  parameter int               TX_DEPTH  = 16,
  parameter int               RX_DEPTH  = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd433
) (
  input  logic               clk,
  input  logic               reset_n,
  uart_avalon_ctrl_if.slave  avs,
  output logic               core_baud_tick,
  output logic               core_tx_valid,
  input  logic               core_tx_ready,
  output logic [7:0]         core_tx_data,
  input  logic               core_rx_ready,
  input  logic [7:0]         core_rx_data
);
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              rx_overrun_q, rx_overrun_d, tx_overflow_q, tx_overflow_d;
  logic              irq_q, irq_d;
  logic [31:0]       readdata_q, readdata_d;

  logic wr_data, wr_status, wr_div, wr_ctrl, rd_data;
  logic flush_tx, flush_rx, tx_pop, tx_drop, rx_drop;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] rx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic [STATUS_W-1:0] status;

  assign wr_data   = avs.avs_write && (avs.avs_address == ADDR_DATA);
  assign wr_status = avs.avs_write && (avs.avs_address == ADDR_STATUS);
  assign wr_div    = avs.avs_write && (avs.avs_address == ADDR_DIV);
  assign wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign rd_data   = avs.avs_read  && (avs.avs_address == ADDR_DATA);
  assign flush_tx  = wr_ctrl && avs.avs_writedata[CTRL_FLUSH_TX];
  assign flush_rx  = wr_ctrl && avs.avs_writedata[CTRL_FLUSH_RX];

  // Clearing tx_en only masks valid; the head byte stays queued.
  assign core_tx_valid = ctrl_q[CTRL_TX_EN] && !tx_empty;
  assign tx_pop        = core_tx_valid && core_tx_ready;
  // A drop is a push that finds no room; a flush-discarded push is not a drop.
  assign tx_drop = wr_data && tx_full && !tx_pop && !flush_tx;
  assign rx_drop = core_rx_ready && rx_full && !rd_data && !flush_rx;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(wr_data), .pop_i(tx_pop), .flush_i(flush_tx),
    .data_i(avs.avs_writedata[7:0]), .data_o(core_tx_data), .full_o(tx_full),
    .empty_o(tx_empty), .count_o(tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(core_rx_ready), .pop_i(rd_data), .flush_i(flush_rx),
    .data_i(core_rx_data), .data_o(rx_head), .full_o(rx_full),
    .empty_o(rx_empty), .count_o(rx_count)
  );

  // Occupancy counts and the upper write-data bits have no consumer here.
  logic unused_bits;
  assign unused_bits = ^{tx_count, rx_count, avs.avs_writedata[31:16]};

  assign status[ST_RX_NOT_EMPTY] = !rx_empty;
  assign status[ST_TX_EMPTY]     = tx_empty;
  assign status[ST_TX_FULL]      = tx_full;
  assign status[ST_RX_FULL]      = rx_full;
  assign status[ST_RX_OVERRUN]   = rx_overrun_q;
  assign status[ST_TX_OVERFLOW]  = tx_overflow_q;

  // Baud down-counter: pulse and reload at zero; a DIVISOR write restarts the period.
  always_comb begin
    cnt_d  = cnt_q - 1'b1;
    tick_d = 1'b0;
    if (wr_div) begin
      cnt_d = avs.avs_writedata[DIV_W-1:0];
    end else if (cnt_q == '0) begin
      cnt_d  = div_q;
      tick_d = 1'b1;
    end
  end

  // Register writes, sticky flags (set beats W1C), interrupt and read mux.
  always_comb begin
    div_d  = wr_div  ? avs.avs_writedata[DIV_W-1:0]  : div_q;
    ctrl_d = wr_ctrl ? avs.avs_writedata[CTRL_W-1:0] : ctrl_q;
    rx_overrun_d  = (rx_overrun_q  && !(wr_status && avs.avs_writedata[ST_RX_OVERRUN]))  || rx_drop;
    tx_overflow_d = (tx_overflow_q && !(wr_status && avs.avs_writedata[ST_TX_OVERFLOW])) || tx_drop;
    irq_d = (ctrl_q[CTRL_IE_RX] && !rx_empty) || (ctrl_q[CTRL_IE_TX] && tx_empty) ||
            (ctrl_q[CTRL_IE_ERR] && (rx_overrun_q || tx_overflow_q));
    readdata_d = '0;
    if (avs.avs_read) begin
      case (avs.avs_address)
        ADDR_DATA:   if (!rx_empty) readdata_d = {23'd0, 1'b1, rx_head};
        ADDR_STATUS: readdata_d[STATUS_W-1:0] = status;
        ADDR_DIV:    readdata_d[DIV_W-1:0] = div_q;
        default:     readdata_d[CTRL_W-1:0] = ctrl_q;
      endcase
    end
  end

  // State registers, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= DIV_RESET;
      cnt_q         <= DIV_RESET;
      tick_q        <= 1'b0;
      ctrl_q        <= '0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      irq_q         <= 1'b0;
      readdata_q    <= '0;
    end else begin
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      ctrl_q        <= ctrl_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      irq_q         <= irq_d;
      readdata_q    <= readdata_d;
    end
  end

  assign core_baud_tick   = tick_q;
  assign avs.avs_readdata = readdata_q;
  assign avs.irq          = irq_q;
endmodule

// File: tb/tb_uart_avalon_ctrl.sv
// Bench for uart_avalon_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_avalon_ctrl;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       core_tx_ready = 1'b0;
  logic       core_rx_ready = 1'b0;
  logic [7:0] core_rx_data = 8'd0;
  logic       core_baud_tick, core_tx_valid;
  logic [7:0] core_tx_data;

  uart_avalon_ctrl_if bus();

  uart_avalon_ctrl dut (
    .clk(clk), .reset_n(reset_n), .avs(bus),
    .core_baud_tick(core_baud_tick), .core_tx_valid(core_tx_valid),
    .core_tx_ready(core_tx_ready), .core_tx_data(core_tx_data),
    .core_rx_ready(core_rx_ready), .core_rx_data(core_rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [3:0]  m_ctrl = 4'd0;
  logic [15:0] m_div = 16'd433;
  bit          m_ovr = 0, m_ovf = 0;
  longint      m_edge = 0, m_reload = 0;
  bit          exp_tick = 0, exp_irq = 0, exp_rd_chk = 1;
  logic [31:0] exp_rd = 0;
  bit          w_data, w_stat, w_div, w_ctrl, r_data, tx_pop, ftx, frx, set_ovf, set_ovr;
  logic [31:0] m_wd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txq.delete(); rxq.delete();
      m_ctrl = 0; m_div = 16'd433; m_ovr = 0; m_ovf = 0;
      m_edge = 0; m_reload = 0;
      exp_tick = 0; exp_irq = 0; exp_rd = 0; exp_rd_chk = 1;
    end else begin
      m_edge++;
      m_wd   = bus.avs_writedata;
      w_data = bus.avs_write && bus.avs_address == 2'd0;
      w_stat = bus.avs_write && bus.avs_address == 2'd1;
      w_div  = bus.avs_write && bus.avs_address == 2'd2;
      w_ctrl = bus.avs_write && bus.avs_address == 2'd3;
      r_data = bus.avs_read  && bus.avs_address == 2'd0;
      ftx = w_ctrl && m_wd[8];
      frx = w_ctrl && m_wd[9];
      tx_pop = m_ctrl[0] && txq.size() != 0 && core_tx_ready;
      set_ovf = 0; set_ovr = 0;
      // read result and interrupt come from the state before this edge
      exp_rd_chk = bus.avs_read;
      exp_rd = 0;
      if (bus.avs_read) begin
        case (bus.avs_address)
          2'd0: if (rxq.size() != 0) exp_rd = 32'h100 | 32'(rxq[0]);
          2'd1: exp_rd = {26'd0, m_ovf, m_ovr, rxq.size() == DEPTH, txq.size() == DEPTH,
                          txq.size() == 0, rxq.size() != 0};
          2'd2: exp_rd = 32'(m_div);
          default: exp_rd = 32'(m_ctrl);
        endcase
      end
      exp_irq = (m_ctrl[1] && rxq.size() != 0) || (m_ctrl[2] && txq.size() == 0) ||
                (m_ctrl[3] && (m_ovr || m_ovf));
      if (ftx) txq.delete();
      else begin
        if (tx_pop) void'(txq.pop_front());
        if (w_data) begin
          if (txq.size() < DEPTH) txq.push_back(m_wd[7:0]);
          else set_ovf = 1;
        end
      end
      if (frx) rxq.delete();
      else begin
        if (r_data && rxq.size() != 0) void'(rxq.pop_front());
        if (core_rx_ready) begin
          if (rxq.size() < DEPTH) rxq.push_back(core_rx_data);
          else set_ovr = 1;
        end
      end
      if (w_stat && m_wd[4]) m_ovr = 0;
      if (w_stat && m_wd[5]) m_ovf = 0;
      if (set_ovr) m_ovr = 1;
      if (set_ovf) m_ovf = 1;
      if (w_ctrl) m_ctrl = m_wd[3:0];
      if (w_div) begin
        m_div = m_wd[15:0];
        m_reload = m_edge;
      end
      // ticks fall on every (DIVISOR+1)-th edge counted from the last reload
      exp_tick = (m_edge > m_reload) && (((m_edge - m_reload) % (longint'(m_div) + 1)) == 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("tick", core_baud_tick, exp_tick);
    chk("irq", bus.irq, exp_irq);
    chk("tx_valid", core_tx_valid, m_ctrl[0] && txq.size() != 0);
    if (m_ctrl[0] && txq.size() != 0) chk("tx_data", core_tx_data, txq[0]);
    if (exp_rd_chk) chk("readdata", bus.avs_readdata, exp_rd);
  end

  // ---------------- stimulus helpers (called at a negedge, consume one cycle) ----------------
  task automatic drv(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] wd,
                     input bit rxp, input logic [7:0] rxd);
    bus.avs_read = rd; bus.avs_write = wr; bus.avs_address = a; bus.avs_writedata = wd;
    core_rx_ready = rxp; core_rx_data = rxd;
    @(negedge clk);
    bus.avs_read = 0; bus.avs_write = 0; core_rx_ready = 0;
  endtask

  task automatic rreg(input logic [1:0] a, output logic [31:0] d);
    drv(1, 0, a, 32'd0, 0, 8'd0);
    d = bus.avs_readdata;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    drv(0, 1, a, d, 0, 8'd0);
  endtask

  task automatic random_traffic(input int n);
    logic [31:0] wd;
    logic [1:0]  a;
    for (int i = 0; i < n; i++) begin
      a = 2'($urandom_range(0, 3));
      case (a)
        2'd0: wd = 32'($urandom_range(0, 255));
        2'd1: wd = 32'($urandom_range(0, 3)) << 4;
        2'd2: wd = 32'($urandom_range(0, 5));
        default: wd = 32'($urandom_range(0, 15)) |
                      (($urandom_range(0, 19) == 0) ? (32'($urandom_range(1, 3)) << 8) : 32'd0);
      endcase
      core_tx_ready = 1'($urandom_range(0, 1));
      drv($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, a, wd,
          $urandom_range(0, 9) < 3, 8'($urandom_range(0, 255)));
    end
    core_tx_ready = 0;
  endtask

  logic [31:0] d;
  int cnt;

  initial begin
    bus.avs_read = 0; bus.avs_write = 0; bus.avs_address = 0; bus.avs_writedata = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;

    // reset values
    rreg(ADDR_DATA, d);   chk("rst_data", d, 32'h0);
    rreg(ADDR_STATUS, d); chk("rst_status", d, 32'h2);
    rreg(ADDR_DIV, d);    chk("rst_div", d, 32'd433);
    rreg(ADDR_CTRL, d);   chk("rst_ctrl", d, 32'h0);
    chk("rst_irq", bus.irq, 0);

    // baud divisor 3 -> 4 ticks in 16 cycles; divisor 0 -> tick every cycle
    wreg(ADDR_DIV, 32'd3);
    cnt = 0;
    repeat (16) begin @(negedge clk); if (core_baud_tick) cnt++; end
    chk("tick_div3", cnt, 4);
    wreg(ADDR_DIV, 32'd0);
    cnt = 0;
    repeat (8) begin @(negedge clk); if (core_baud_tick) cnt++; end
    chk("tick_div0", cnt, 8);
    wreg(ADDR_DIV, 32'd7);

    // TX gating, hold under backpressure, ordering
    wreg(ADDR_CTRL, 32'h0);
    wreg(ADDR_DATA, 32'h41);
    wreg(ADDR_DATA, 32'h42);
    chk("tx_valid_off", core_tx_valid, 0);
    wreg(ADDR_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("tx_hold_valid", core_tx_valid, 1);
      chk("tx_hold_data", core_tx_data, 8'h41);
      @(negedge clk);
    end
    core_tx_ready = 1;
    @(negedge clk);
    chk("tx_second", core_tx_data, 8'h42);
    @(negedge clk);
    chk("tx_drained", core_tx_valid, 0);
    core_tx_ready = 0;

    // TX overflow, W1C, flush
    wreg(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) wreg(ADDR_DATA, 32'(i));
    rreg(ADDR_STATUS, d); chk("tx_overflow_status", d, 32'h24);
    wreg(ADDR_STATUS, 32'h20);
    rreg(ADDR_STATUS, d); chk("tx_overflow_w1c", d, 32'h04);
    wreg(ADDR_CTRL, 32'h100);
    rreg(ADDR_STATUS, d); chk("tx_flush", d, 32'h02);

    // RX overrun, drain order, error interrupt
    wreg(ADDR_CTRL, 32'h8);
    for (int i = 0; i < 17; i++) drv(0, 0, ADDR_DATA, 0, 1, 8'(i));
    rreg(ADDR_STATUS, d); chk("rx_overrun_status", d, 32'h1B);
    chk("irq_err_set", bus.irq, 1);
    for (int i = 0; i < 16; i++) begin
      rreg(ADDR_DATA, d); chk("rx_drain", d, 32'h100 + 32'(i));
    end
    rreg(ADDR_DATA, d); chk("rx_empty_read", d, 32'h0);
    wreg(ADDR_STATUS, 32'h10);
    @(negedge clk);
    chk("irq_err_clear", bus.irq, 0);

    // RX full with pulse and read together: kept, appended last
    wreg(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 16; i++) drv(0, 0, ADDR_DATA, 0, 1, 8'h20 + 8'(i));
    drv(1, 0, ADDR_DATA, 0, 1, 8'h55);
    chk("rx_full_pop", bus.avs_readdata, 32'h120);
    rreg(ADDR_STATUS, d); chk("rx_full_no_overrun", d, 32'h0B);
    for (int i = 1; i < 16; i++) begin
      rreg(ADDR_DATA, d); chk("rx_full_drain", d, 32'h120 + 32'(i));
    end
    rreg(ADDR_DATA, d); chk("rx_new_last", d, 32'h155);

    // empty + push + read together: read invalid, byte kept
    drv(1, 0, ADDR_DATA, 0, 1, 8'h66);
    chk("rx_empty_pushpop", bus.avs_readdata, 32'h0);
    rreg(ADDR_STATUS, d); chk("rx_empty_kept", d, 32'h03);
    rreg(ADDR_DATA, d);   chk("rx_kept_byte", d, 32'h166);

    // flush RX with a same-cycle pulse
    drv(0, 0, ADDR_DATA, 0, 1, 8'h77);
    drv(0, 1, ADDR_CTRL, 32'h200, 1, 8'h88);
    rreg(ADDR_STATUS, d); chk("rx_flush", d, 32'h02);

    // randomized traffic against the model
    random_traffic(3000);

    // asynchronous reset in the middle of activity
    wreg(ADDR_CTRL, 32'h0);
    wreg(ADDR_DATA, 32'h5A);
    wreg(ADDR_CTRL, 32'h1);
    #2 reset_n = 0;
    repeat (2) @(negedge clk);
    chk("midrst_tx_valid", core_tx_valid, 0);
    chk("midrst_irq", bus.irq, 0);
    reset_n = 1;
    rreg(ADDR_STATUS, d); chk("midrst_status", d, 32'h02);
    rreg(ADDR_DIV, d);    chk("midrst_div", d, 32'd433);
    random_traffic(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
